huffman_packer: RTL

- Downstream stage of the Huffman table builder.
- Captures the six-entry code table (HC1..HC6 codes, M1..M6 masks) when code_valid pulses.
- Re-encodes a stream of gray-level symbols (1..6) into a packed, MSB-first byte stream with ready/valid handshakes.
- Handles flush/padding at end of frame and keeps a code-bit count for the frame.

---
 rtl/huffman_packer_pkg.sv | 28 ++
 rtl/huffman_code_lut.sv | 48 ++++
 rtl/huffman_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/huffman_packer_pkg.sv
// Shared types and constants for the Huffman table builder and the packer.
// Table entries are {hc, mask}; code length is the popcount of the mask.
package huffman_packer_pkg;

  localparam int NSYM     = 6;
  localparam int CODE_W   = 8;
  localparam int BITCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] hc;
    logic [CODE_W-1:0] mask;
  } code_entry_t;

  function automatic logic [3:0] code_len(input logic [CODE_W-1:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Registered six-entry code table with a combinational symbol lookup.
// Returns the code left-aligned in 5 bits plus its length; illegal symbols give len 0.
module huffman_code_lut
  import huffman_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  code_entry_t [NSYM-1:0] tbl_i,
  input  logic [2:0]             sym_i,
  output logic [4:0]             bits_o,
  output logic [3:0]             len_o,
  output logic                   illegal_o,
  output logic                   loaded_o
);

  code_entry_t [NSYM-1:0] tbl_q;
  logic                   loaded_q;
  code_entry_t            entry;
  logic [3:0]             len;
  logic [CODE_W-1:0]      masked;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tbl_q    <= '0;
      loaded_q <= 1'b0;
    end else if (load_i) begin
      tbl_q    <= tbl_i;
      loaded_q <= 1'b1;
    end
  end

  // Out-of-range symbols select an all-zero entry, so they fall out as len 0.
  always_comb begin
    entry = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (sym_i == 3'(i + 1)) entry = tbl_q[i];
    end
    len       = code_len(entry.mask);
    masked    = entry.hc & entry.mask;
    illegal_o = (len == 4'd0) || (len > 4'd5);
    bits_o    = illegal_o ? 5'd0 : 5'(masked << (4'd5 - len));
    len_o     = illegal_o ? 4'd0 : len;
  end

  assign loaded_o = loaded_q;

endmodule

// File: rtl/huffman_packer.sv
// Packs Huffman codes for gray-level symbols into an MSB-first byte stream.
//  state | meaning
//  IDLE  | no table loaded yet, symbols refused
//  RUN   | accepting symbols while the accumulator holds <= 7 bits
//  FLUSH | frame ended: drain full bytes, then a zero-padded remainder
//  DONE  | one-cycle done pulse, frame counters cleared on exit
module huffman_packer
  import huffman_packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   HC1, HC2, HC3, HC4, HC5, HC6,
  input  logic [CODE_W-1:0]   M1, M2, M3, M4, M5, M6,
  input  logic                sym_valid,
  input  logic [2:0]          sym_data,
  input  logic                sym_last,
  output logic                sym_ready,
  output logic                out_valid,
  output logic [7:0]          out_byte,
  output logic                out_last,
  input  logic                out_ready,
  output logic [BITCNT_W-1:0] bit_count,
  output logic                sym_err,
  output logic                done
);

  state_e                 state_q;
  logic [11:0]            acc_q, acc_d, acc_rem;
  logic [3:0]             acc_cnt_q, acc_cnt_d, cnt_rem;
  logic [7:0]             out_byte_q;
  logic                   out_valid_q, out_last_q, done_q, sym_err_q;
  logic [BITCNT_W-1:0]    bit_count_q;
  code_entry_t [NSYM-1:0] tbl;
  logic [4:0]             lut_bits;
  logic [3:0]             lut_len;
  logic                   lut_illegal, loaded;
  logic                   accept, slot_free, pop, frame_end, last_d;
  logic [BITCNT_W:0]      bc_sum;

  assign tbl = {code_entry_t'{HC6, M6}, code_entry_t'{HC5, M5}, code_entry_t'{HC4, M4},
                code_entry_t'{HC3, M3}, code_entry_t'{HC2, M2}, code_entry_t'{HC1, M1}};

  huffman_code_lut u_lut (
    .clk       (clk),
    .reset     (reset),
    .load_i    (code_valid && (state_q != ST_FLUSH)),
    .tbl_i     (tbl),
    .sym_i     (sym_data),
    .bits_o    (lut_bits),
    .len_o     (lut_len),
    .illegal_o (lut_illegal),
    .loaded_o  (loaded)
  );

  assign sym_ready = (state_q == ST_RUN) && (acc_cnt_q <= 4'd7);
  assign accept    = sym_valid && sym_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign pop       = slot_free && ((acc_cnt_q >= 4'd8) ||
                                   ((state_q == ST_FLUSH) && (acc_cnt_q != 4'd0)));
  assign frame_end = (state_q == ST_FLUSH) || (accept && sym_last);

  // Remove the outgoing byte first, then append the new code behind what is left.
  always_comb begin
    acc_rem = acc_q;
    cnt_rem = acc_cnt_q;
    if (pop) begin
      acc_rem = acc_q << 8;
      cnt_rem = (acc_cnt_q >= 4'd8) ? acc_cnt_q - 4'd8 : 4'd0;
    end
    acc_d     = acc_rem;
    acc_cnt_d = cnt_rem;
    if (accept) begin
      acc_d     = acc_rem | ({lut_bits, 7'b0} >> cnt_rem);
      acc_cnt_d = cnt_rem + lut_len;
    end
    last_d = frame_end && (acc_cnt_d == 4'd0);
    bc_sum = {1'b0, bit_count_q} + (BITCNT_W + 1)'(lut_len);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sym_err_q   <= 1'b0;
      bit_count_q <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      done_q    <= 1'b0;
      if (pop) begin
        out_byte_q  <= acc_q[11:4];
        out_valid_q <= 1'b1;
        out_last_q  <= last_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (accept) begin
        if (lut_illegal) sym_err_q <= 1'b1;
        else bit_count_q <= bc_sum[BITCNT_W] ? '1 : bc_sum[BITCNT_W-1:0];
      end
      case (state_q)
        ST_IDLE:  if (loaded) state_q <= ST_RUN;
        ST_RUN:   if (accept && sym_last) state_q <= ST_FLUSH;
        ST_FLUSH: if ((acc_cnt_q == 4'd0) && slot_free) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q     <= ST_RUN;
          bit_count_q <= '0;
          sym_err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign bit_count = bit_count_q;
  assign sym_err   = sym_err_q;
  assign done      = done_q;

endmodule
